// File: rtl/coin_collect.sv
// coin_collect: scans Mario's latched bounding box against a fixed row of coins,
// clears overlapped coins, keeps a saturating 2-digit BCD score and respawns
// the row a fixed number of frame ticks after the last coin is taken.
module coin_collect #(
  parameter int unsigned NUM_COINS      = 8,
  parameter int unsigned COIN_X0        = 64,
  parameter int unsigned COIN_PITCH     = 32,
  parameter int unsigned COIN_Y         = 400,
  parameter int unsigned COIN_SIZE      = 16,
  parameter int unsigned MARIO_W        = 32,
  parameter int unsigned MARIO_H        = 40,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [9:0]           mario_left,
  input  logic [9:0]           mario_top,
  output logic [NUM_COINS-1:0] coin_alive,
  output logic [7:0]           score,
  output logic                 collect_pulse,
  output logic                 all_collected,
  output logic                 busy
);

  localparam int unsigned IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int unsigned CNT_W = $clog2(RESPAWN_FRAMES) + 1;
  localparam int unsigned SUM_W = 11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SCAN         = 2'd1,
    RESPAWN_WAIT = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     resp_cnt;
  logic [9:0]           lat_left;
  logic [9:0]           lat_top;

  logic [SUM_W-1:0]     coin_x;
  logic [SUM_W-1:0]     box_l;
  logic [SUM_W-1:0]     box_t;
  logic                 hit;
  logic [NUM_COINS-1:0] alive_upd;
  logic [7:0]           score_inc;

  // Overlap test for coin idx, the post-hit alive vector and the next BCD score
  always_comb begin
    coin_x    = SUM_W'(COIN_X0) + SUM_W'(idx) * SUM_W'(COIN_PITCH);
    box_l     = SUM_W'(lat_left);
    box_t     = SUM_W'(lat_top);
    hit       = coin_alive[idx]
              && (box_l <= coin_x + SUM_W'(COIN_SIZE - 1))
              && (box_l + SUM_W'(MARIO_W - 1) >= coin_x)
              && (box_t <= SUM_W'(COIN_Y + COIN_SIZE - 1))
              && (box_t + SUM_W'(MARIO_H - 1) >= SUM_W'(COIN_Y));
    alive_upd = coin_alive;
    if (hit) begin
      alive_upd[idx] = 1'b0;
    end
    if (score == 8'h99) begin
      score_inc = score;
    end else if (score[3:0] == 4'd9) begin
      score_inc = {score[7:4] + 4'd1, 4'd0};
    end else begin
      score_inc = {score[7:4], score[3:0] + 4'd1};
    end
  end

  // Control FSM with registered outputs: idle, per-coin scan, respawn countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      resp_cnt      <= '0;
      lat_left      <= '0;
      lat_top       <= '0;
      coin_alive    <= '1;
      score         <= 8'h00;
      collect_pulse <= 1'b0;
      all_collected <= 1'b0;
      busy          <= 1'b0;
    end else begin
      collect_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            lat_left <= mario_left;
            lat_top  <= mario_top;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            coin_alive    <= alive_upd;
            collect_pulse <= 1'b1;
            score         <= score_inc;
          end
          all_collected <= (alive_upd == '0);
          if (idx == IDX_W'(NUM_COINS - 1)) begin
            idx   <= '0;
            busy  <= 1'b0;
            state <= (alive_upd == '0) ? RESPAWN_WAIT : IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        RESPAWN_WAIT: begin
          if (frame_tick) begin
            if (resp_cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
              coin_alive    <= '1;
              resp_cnt      <= '0;
              all_collected <= 1'b0;
              state         <= IDLE;
            end else begin
              resp_cnt <= resp_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_collect.sv
// Directed bench for coin_collect: two instances (3-frame and 1-frame respawn).
module tb_coin_collect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] mario_left = '0;
  logic [9:0] mario_top = '0;

  logic [7:0] alive3, score3, alive1, score1;
  logic       pulse3, ac3, busy3, pulse1, ac1, busy1;

  int checks = 0;
  int failures = 0;

  logic [7:0] pmask3, pmask1;
  int         bcnt3, bcnt1;
  logic [8:0] acseq3;

  coin_collect #(.RESPAWN_FRAMES(3)) u_dut3 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .mario_left(mario_left), .mario_top(mario_top),
    .coin_alive(alive3), .score(score3), .collect_pulse(pulse3),
    .all_collected(ac3), .busy(busy3)
  );

  coin_collect #(.RESPAWN_FRAMES(1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .mario_left(mario_left), .mario_top(mario_top),
    .coin_alive(alive1), .score(score1), .collect_pulse(pulse1),
    .all_collected(ac1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One tick with the given box, then nine samples: j=0 right after the tick edge k,
  // j=1..8 after edges k+1..k+8. Inputs are scrambled after the tick.
  task automatic run_scan(input logic [9:0] l, input logic [9:0] t);
    pmask3 = '0; pmask1 = '0; bcnt3 = 0; bcnt1 = 0; acseq3 = '0;
    @(negedge clk);
    mario_left = l; mario_top = t; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; mario_left = 10'd900; mario_top = 10'd0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      if (busy3) bcnt3++;
      if (busy1) bcnt1++;
      if (j > 0 && pulse3) pmask3[j-1] = 1'b1;
      if (j > 0 && pulse1) pmask1[j-1] = 1'b1;
      acseq3[j] = ac3;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (alive3 !== 8'hFF) begin failures++; $display("FAIL reset_alive: got %h expected ff", alive3); end
    checks++; if (score3 !== 8'h00) begin failures++; $display("FAIL reset_score: got %h expected 00", score3); end
    checks++; if (pulse3 !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b expected 0", pulse3); end
    checks++; if (ac3 !== 1'b0) begin failures++; $display("FAIL reset_all_collected: got %b expected 0", ac3); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy3); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ground_then_jump;
    do_reset();
    run_scan(10'd60, 10'd440);
    checks++; if (pmask3 !== 8'h00) begin failures++; $display("FAIL ground_pulses: got %h expected 00", pmask3); end
    checks++; if (bcnt3 != 8) begin failures++; $display("FAIL ground_busy_len: got %0d expected 8", bcnt3); end
    checks++; if (alive3 !== 8'hFF) begin failures++; $display("FAIL ground_alive: got %h expected ff", alive3); end
    checks++; if (score3 !== 8'h00) begin failures++; $display("FAIL ground_score: got %h expected 00", score3); end
    run_scan(10'd60, 10'd410);
    checks++; if (pmask3 !== 8'h01) begin failures++; $display("FAIL jump_pulses: got %h expected 01", pmask3); end
    checks++; if (alive3 !== 8'hFE) begin failures++; $display("FAIL jump_alive: got %h expected fe", alive3); end
    checks++; if (score3 !== 8'h01) begin failures++; $display("FAIL jump_score: got %h expected 01", score3); end
    checks++; if (bcnt3 != 8) begin failures++; $display("FAIL jump_busy_len: got %0d expected 8", bcnt3); end
  endtask

  task automatic test_double_hit;
    do_reset();
    run_scan(10'd70, 10'd410);
    checks++; if (pmask3 !== 8'h03) begin failures++; $display("FAIL double_pulses: got %h expected 03", pmask3); end
    checks++; if (alive3 !== 8'hFC) begin failures++; $display("FAIL double_alive: got %h expected fc", alive3); end
    checks++; if (score3 !== 8'h02) begin failures++; $display("FAIL double_score: got %h expected 02", score3); end
    run_scan(10'd70, 10'd410);
    checks++; if (pmask3 !== 8'h00) begin failures++; $display("FAIL double_repeat_pulses: got %h expected 00", pmask3); end
    checks++; if (alive3 !== 8'hFC) begin failures++; $display("FAIL double_repeat_alive: got %h expected fc", alive3); end
    checks++; if (score3 !== 8'h02) begin failures++; $display("FAIL double_repeat_score: got %h expected 02", score3); end
  endtask

  task automatic test_respawn;
    logic [9:0] lpos [4];
    logic [7:0] em;
    lpos = '{10'd70, 10'd134, 10'd198, 10'd262};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      run_scan(lpos[p], 10'd410);
      em = 8'h03;
      em = em << (2 * p);
      checks++; if (pmask3 !== em) begin failures++; $display("FAIL respawn_collect_pulses p=%0d: got %h expected %h", p, pmask3, em); end
    end
    checks++; if (alive3 !== 8'h00) begin failures++; $display("FAIL respawn_all_gone: got %h expected 00", alive3); end
    checks++; if (ac3 !== 1'b1) begin failures++; $display("FAIL respawn_all_collected: got %b expected 1", ac3); end
    checks++; if (score3 !== 8'h08) begin failures++; $display("FAIL respawn_score: got %h expected 08", score3); end
    checks++; if (acseq3[8:7] !== 2'b10) begin failures++; $display("FAIL respawn_ac_timing: got %b expected 10", acseq3[8:7]); end
    for (int r = 0; r < 3; r++) begin
      run_scan(10'd70, 10'd410);
      checks++; if (bcnt3 != 0) begin failures++; $display("FAIL respawn_wait_busy r=%0d: got %0d expected 0", r, bcnt3); end
      checks++; if (pmask3 !== 8'h00) begin failures++; $display("FAIL respawn_wait_pulses r=%0d: got %h expected 00", r, pmask3); end
      if (r < 2) begin
        checks++; if (alive3 !== 8'h00 || ac3 !== 1'b1) begin failures++; $display("FAIL respawn_wait_state r=%0d: got alive=%h ac=%b expected alive=00 ac=1", r, alive3, ac3); end
      end else begin
        checks++; if (alive3 !== 8'hFF) begin failures++; $display("FAIL respawn_alive: got %h expected ff", alive3); end
        checks++; if (ac3 !== 1'b0) begin failures++; $display("FAIL respawn_ac_clear: got %b expected 0", ac3); end
        checks++; if (score3 !== 8'h08) begin failures++; $display("FAIL respawn_score_hold: got %h expected 08", score3); end
      end
    end
  endtask

  task automatic test_bcd_saturation;
    logic [9:0] lpos [4];
    logic [7:0] em;
    logic [7:0] eb;
    int n;
    int d;
    lpos = '{10'd70, 10'd134, 10'd198, 10'd262};
    n = 0;
    do_reset();
    for (int rnd = 0; rnd < 13; rnd++) begin
      for (int p = 0; p < 4; p++) begin
        run_scan(lpos[p], 10'd410);
        n += 2;
        d = (n > 99) ? 99 : n;
        eb = {4'(d / 10), 4'(d % 10)};
        em = 8'h03;
        em = em << (2 * p);
        checks++; if (pmask1 !== em) begin failures++; $display("FAIL bcd_pulses n=%0d: got %h expected %h", n, pmask1, em); end
        checks++; if (score1 !== eb) begin failures++; $display("FAIL bcd_score n=%0d: got %h expected %h", n, score1, eb); end
      end
      run_scan(10'd70, 10'd410);
      checks++; if (alive1 !== 8'hFF || ac1 !== 1'b0) begin failures++; $display("FAIL bcd_respawn rnd=%0d: got alive=%h ac=%b expected alive=ff ac=0", rnd, alive1, ac1); end
      checks++; if (pmask1 !== 8'h00) begin failures++; $display("FAIL bcd_respawn_pulses rnd=%0d: got %h expected 00", rnd, pmask1); end
    end
  endtask

  task automatic test_ignored_tick;
    int c3;
    int c1;
    do_reset();
    c3 = 0; c1 = 0;
    @(negedge clk);
    mario_left = 10'd60; mario_top = 10'd440; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (busy3) c3++;
    if (busy1) c1++;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (busy3) c3++;
      if (busy1) c1++;
      if (j == 2) frame_tick = 1'b1;
      if (j == 3) frame_tick = 1'b0;
    end
    checks++; if (c3 != 8) begin failures++; $display("FAIL ignored_tick_busy3: got %0d expected 8", c3); end
    checks++; if (c1 != 8) begin failures++; $display("FAIL ignored_tick_busy1: got %0d expected 8", c1); end
  endtask

  task automatic test_reset_mid_scan;
    do_reset();
    @(negedge clk);
    mario_left = 10'd70; mario_top = 10'd410; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (alive3 !== 8'hFC || score3 !== 8'h02) begin failures++; $display("FAIL midscan_pre: got alive=%h score=%h expected alive=fc score=02", alive3, score3); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (alive3 !== 8'hFF) begin failures++; $display("FAIL midscan_alive: got %h expected ff", alive3); end
    checks++; if (score3 !== 8'h00) begin failures++; $display("FAIL midscan_score: got %h expected 00", score3); end
    checks++; if (busy3 !== 1'b0 || pulse3 !== 1'b0 || ac3 !== 1'b0) begin failures++; $display("FAIL midscan_flags: got busy=%b pulse=%b ac=%b expected 0 0 0", busy3, pulse3, ac3); end
    @(negedge clk);
    rst = 1'b1;
    run_scan(10'd60, 10'd440);
    checks++; if (bcnt3 != 8 || alive3 !== 8'hFF) begin failures++; $display("FAIL midscan_recover: got busy_len=%0d alive=%h expected 8 ff", bcnt3, alive3); end
  endtask

  initial begin
    test_reset();
    test_ground_then_jump();
    test_double_hit();
    test_respawn();
    test_bcd_saturation();
    test_ignored_tick();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
